// File: rtl/crypto_ahb_cmd_master.sv
`default_nettype none
// =====================================================================
// crypto_ahb_cmd_master : valid/ready command sequencer for the CRYPTO
// core's AHB-Lite slave port and START/PURGE control pins.
// Revision 1.0
// =====================================================================
module crypto_ahb_cmd_master #(
   parameter int unsigned ADDR_W      = 17,
   parameter int unsigned TIMEOUT_W   = 16,
   parameter int unsigned TIMEOUT_MAX = 65535
) (
   input  logic              HCLK,
   input  logic              HRESETN,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_status,
   output logic              S_HSEL,
   output logic [ADDR_W-1:0] S_HADDR,
   output logic [31:0]       S_HWDATA,
   output logic [1:0]        S_HSIZE,
   output logic [1:0]        S_HTRANS,
   output logic              S_HWRITE,
   output logic              S_HREADY,
   input  logic              S_HREADYOUT,
   input  logic              S_HRESP,
   input  logic [31:0]       S_HRDATA,
   output logic              START,
   output logic              PURGE,
   input  logic              BUSY,
   input  logic              COMPLETE,
   input  logic              ALARM
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_DATA  = 3'd2,
      ST_ERR   = 3'd3,
      ST_PULSE = 3'd4,
      ST_WAIT  = 3'd5,
      ST_RESP  = 3'd6
   } state_t;

   localparam logic [1:0] c_op_write     = 2'b00;
   localparam logic [1:0] c_op_read      = 2'b01;
   localparam logic [1:0] c_op_start     = 2'b10;
   localparam logic [1:0] c_op_purge     = 2'b11;
   localparam logic [1:0] c_htrans_idle  = 2'b00;
   localparam logic [1:0] c_htrans_nseq  = 2'b10;
   // CRYPTO exposes a 2-bit HSIZE; 2'b10 selects a 32-bit word transfer
   localparam logic [1:0] c_hsize_word   = 2'b10;
   localparam logic [1:0] c_st_ok        = 2'b00;
   localparam logic [1:0] c_st_buserr    = 2'b01;
   localparam logic [1:0] c_st_timeout   = 2'b10;
   localparam logic [1:0] c_st_alarm     = 2'b11;
   localparam logic [TIMEOUT_W-1:0] c_timeout_max = TIMEOUT_W'(TIMEOUT_MAX);

   state_t                state_q;
   logic [1:0]            op_q;
   logic [31:0]           wdata_q;
   logic [TIMEOUT_W-1:0]  timer_q;
   logic                  cmd_ready_q;
   logic                  rsp_valid_q;
   logic [31:0]           rsp_rdata_q;
   logic [1:0]            rsp_status_q;
   logic                  hsel_q;
   logic [ADDR_W-1:0]     haddr_q;
   logic [31:0]           hwdata_q;
   logic [1:0]            hsize_q;
   logic [1:0]            htrans_q;
   logic                  hwrite_q;
   logic                  start_q;
   logic                  purge_q;

   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state_q      <= ST_IDLE;
         op_q         <= c_op_write;
         wdata_q      <= '0;
         timer_q      <= '0;
         cmd_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_status_q <= c_st_ok;
         hsel_q       <= 1'b0;
         haddr_q      <= '0;
         hwdata_q     <= '0;
         hsize_q      <= '0;
         htrans_q     <= c_htrans_idle;
         hwrite_q     <= 1'b0;
         start_q      <= 1'b0;
         purge_q      <= 1'b0;
      end else begin
         start_q <= 1'b0;
         purge_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  op_q        <= cmd_op;
                  wdata_q     <= cmd_wdata;
                  rsp_rdata_q <= '0;
                  if (!cmd_op[1]) begin
                     state_q  <= ST_ADDR;
                     hsel_q   <= 1'b1;
                     htrans_q <= c_htrans_nseq;
                     hsize_q  <= c_hsize_word;
                     hwrite_q <= (cmd_op == c_op_write);
                     haddr_q  <= cmd_addr;
                  end else begin
                     state_q <= ST_PULSE;
                     start_q <= (cmd_op == c_op_start);
                     purge_q <= (cmd_op == c_op_purge);
                  end
               end
            end
            ST_ADDR: begin
               if (S_HREADYOUT) begin
                  state_q  <= ST_DATA;
                  hsel_q   <= 1'b0;
                  htrans_q <= c_htrans_idle;
                  hwdata_q <= wdata_q;
               end
            end
            ST_DATA: begin
               if (S_HRESP) begin
                  // a malformed one-cycle error still reports a bus error
                  if (S_HREADYOUT) begin
                     rsp_status_q <= c_st_buserr;
                     rsp_valid_q  <= 1'b1;
                     state_q      <= ST_RESP;
                  end else begin
                     state_q <= ST_ERR;
                  end
               end else if (S_HREADYOUT) begin
                  if (op_q == c_op_read) begin
                     rsp_rdata_q <= S_HRDATA;
                  end
                  rsp_status_q <= c_st_ok;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= ST_RESP;
               end
            end
            ST_ERR: begin
               if (S_HREADYOUT) begin
                  rsp_status_q <= c_st_buserr;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= ST_RESP;
               end
            end
            ST_PULSE: begin
               timer_q <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (ALARM) begin
                  rsp_status_q <= c_st_alarm;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= ST_RESP;
               end else if ((op_q == c_op_start) && COMPLETE) begin
                  rsp_status_q <= c_st_ok;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= ST_RESP;
               end else if ((op_q == c_op_purge) && !BUSY && (timer_q != '0)) begin
                  // BUSY is ignored on the first wait cycle: the core may not have raised it yet
                  rsp_status_q <= c_st_ok;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= ST_RESP;
               end else if (timer_q == c_timeout_max) begin
                  rsp_status_q <= c_st_timeout;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  timer_q <= timer_q + TIMEOUT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_status = rsp_status_q;
   assign S_HSEL     = hsel_q;
   assign S_HADDR    = haddr_q;
   assign S_HWDATA   = hwdata_q;
   assign S_HSIZE    = hsize_q;
   assign S_HTRANS   = htrans_q;
   assign S_HWRITE   = hwrite_q;
   assign S_HREADY   = S_HREADYOUT;
   assign START      = start_q;
   assign PURGE      = purge_q;

endmodule

`default_nettype wire
